timeout_timer: RTL and testbench

TIMEOUT_TIMER -- requirements
Module: timeout_timer

---
 rtl/timer_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 34 +++
 rtl/timeout_timer.sv | 85 ++++++++
 tb/tb_timeout_timer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and default parameters for the timeout timer.
// The state encoding is fixed so waveforms read the same across tools.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  localparam int DEF_DIV     = 50_000_000;
  localparam int DEF_TIMEOUT = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: emits one tick on the enabled cycle where the count reaches DIV-1.
// The count then wraps to 0. clr is a synchronous clear that has priority over en.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  // NOTE: sequential state uses non-blocking assignments. Registers that read
  // each other within the same edge then all see the values from before that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/timeout_timer.sv
// Timeout timer: counts prescaled ticks while enabled and latches t0 at TIMEOUT ticks.
// Only rst_timer or rst releases the timer from EXPIRED.
module timeout_timer
  import timer_pkg::*;
#(
  parameter int DIV     = DEF_DIV,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_cont,
  input  logic          rst_timer,
  output logic          t0,
  output logic [CW-1:0] count,
  output logic          busy
);

  localparam logic [CW-1:0] TOP = CW'(TIMEOUT);

  state_t        state, state_nxt;
  logic [CW-1:0] count_nxt;
  logic          t0_nxt;
  logic          presc_en;
  logic          tick;

  // The prescaler is frozen once EXPIRED so that it restarts cleanly after a clear.
  assign presc_en = en_cont && (state != EXPIRED);

  tick_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (rst_timer),
    .en   (presc_en),
    .tick (tick)
  );

  // NOTE: every output of this block is assigned a default before any branch.
  // Without those defaults, a path that skips an assignment infers a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    t0_nxt    = t0;
    if (rst_timer) begin
      state_nxt = IDLE;
      count_nxt = '0;
      t0_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE, RUN, PAUSE: begin
          if (en_cont) begin
            state_nxt = RUN;
            if (tick) begin
              count_nxt = count + CW'(1);
              if (count_nxt == TOP) begin
                state_nxt = EXPIRED;
                t0_nxt    = 1'b1;
              end
            end
          end else if (state == RUN) begin
            state_nxt = PAUSE;
          end
        end
        default: ;  // EXPIRED holds until cleared
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      t0    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      t0    <= t0_nxt;
      busy  <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_timeout_timer.sv
// Bench for timeout_timer (DIV=4, TIMEOUT=5). It runs directed scenarios and then random stimulus.
// Outputs are compared with a model that tracks the number of enabled cycles since the last clear.
module tb_timeout_timer;
  import timer_pkg::*;

  localparam int DIV     = 4;
  localparam int TIMEOUT = 5;
  localparam int CW      = $clog2(TIMEOUT + 1);
  localparam int LIMIT   = DIV * TIMEOUT;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en_cont = 1'b0;
  logic          rst_timer = 1'b0;
  logic          t0;
  logic [CW-1:0] count;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: enabled cycles since the last clear, and whether the last edge left the timer running.
  int m_edges = 0;
  bit m_busy  = 1'b0;

  timeout_timer #(
    .DIV     (DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_cont   (en_cont),
    .rst_timer (rst_timer),
    .t0        (t0),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c;
    c = m_edges / DIV;
    return (c > TIMEOUT) ? TIMEOUT : c;
  endfunction

  function automatic bit m_t0();
    return m_edges >= LIMIT;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_edges = 0;
      m_busy  = 1'b0;
    end else if (rst_timer) begin
      m_edges = 0;
      m_busy  = 1'b0;
    end else if (m_edges >= LIMIT) begin
      m_busy = 1'b0;
    end else if (en_cont) begin
      m_edges++;
      m_busy = (m_edges < LIMIT);
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".t0"}, t0, m_t0());
    check({tag, ".count"}, count, m_count());
    check({tag, ".busy"}, busy, m_busy);
  endtask

  // Drive inputs away from the edge, clock once, update the model, then sample the outputs.
  task automatic cycle(input string tag, input logic e, input logic rt);
    en_cont   = e;
    rst_timer = rt;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // Scenario 1: reset held for two edges, then a continuous run to expiry.
    cycle("s1.rst", 1'b1, 1'b0);
    cycle("s1.rst", 1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < LIMIT - 1; i++) cycle("s1.run", 1'b1, 1'b0);
    check("s1.t0_before", t0, 0);
    cycle("s1.run", 1'b1, 1'b0);
    check("s1.t0_expiry", t0, 1);
    check("s1.count_expiry", count, TIMEOUT);
    check("s1.busy_expiry", busy, 0);
    for (int i = 0; i < 5; i++) cycle("s1.hold", 1'b1, 1'b0);
    cycle("s1.clear", 1'b0, 1'b1);

    // Scenario 2: run 10 edges, pause for 7, then resume to expiry.
    for (int i = 0; i < 10; i++) cycle("s2.run", 1'b1, 1'b0);
    check("s2.count_pause", count, 2);
    for (int i = 0; i < 7; i++) begin
      cycle("s2.pause", 1'b0, 1'b0);
      check("s2.count_held", count, 2);
    end
    for (int i = 0; i < 9; i++) cycle("s2.resume", 1'b1, 1'b0);
    check("s2.t0_before", t0, 0);
    cycle("s2.resume", 1'b1, 1'b0);
    check("s2.t0_expiry", t0, 1);

    // Scenario 4: a one-cycle clear from EXPIRED, then a fresh full run.
    cycle("s4.clear", 1'b0, 1'b1);
    check("s4.state_idle", dut.state, IDLE);
    for (int i = 0; i < LIMIT; i++) cycle("s4.run", 1'b1, 1'b0);
    check("s4.t0_expiry", t0, 1);

    // Scenario 3: clear and enable asserted together; the clear wins on every edge.
    for (int i = 0; i < 30; i++) begin
      cycle("s3.both", 1'b1, 1'b1);
      check("s3.state", dut.state, IDLE);
    end

    // Scenario 5: asynchronous reset at count=3, between clock edges.
    for (int i = 0; i < 3 * DIV; i++) cycle("s5.run", 1'b1, 1'b0);
    check("s5.count_pre", count, 3);
    #2;
    rst = 1'b0;
    #1;
    m_edges = 0;
    m_busy  = 1'b0;
    check("s5.async_t0", t0, 0);
    check("s5.async_count", count, 0);
    check("s5.async_busy", busy, 0);
    cycle("s5.rst_low", 1'b1, 1'b0);
    cycle("s5.rst_low", 1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < LIMIT - 1; i++) cycle("s5.run2", 1'b1, 1'b0);
    check("s5.t0_before", t0, 0);
    cycle("s5.run2", 1'b1, 1'b0);
    check("s5.t0_expiry", t0, 1);

    // Scenario 6: clear on the would-be expiry edge; the clear wins.
    cycle("s6.clear", 1'b0, 1'b1);
    for (int i = 0; i < LIMIT - 1; i++) cycle("s6.run", 1'b1, 1'b0);
    cycle("s6.collide", 1'b1, 1'b1);
    check("s6.t0", t0, 0);
    check("s6.state", dut.state, IDLE);
    cycle("s6.after", 1'b0, 1'b0);
    cycle("s6.after", 1'b0, 1'b0);

    // Random phase: enable mostly high, occasional pauses and clears.
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
